// File: rtl/bresp_route_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// bresp_route_ctrl_pkg
// Shared constants for the two-master AXI interconnect B-channel router.
//   MASTER_0 / MASTER_1 : owner IDs stored in the routing FIFO and driven
//                         onto the B-channel demux select line.
//   DEFAULT_DEPTH       : default number of outstanding writes tracked.
//   BRESP_W             : AXI BRESP width.
// ---------------------------------------------------------------------------
package bresp_route_ctrl_pkg;

   localparam logic MASTER_0      = 1'b0;
   localparam logic MASTER_1      = 1'b1;
   localparam int   DEFAULT_DEPTH = 4;
   localparam int   BRESP_W       = 2;

endpackage : bresp_route_ctrl_pkg

// File: rtl/bresp_route_ctrl_sel_fifo.sv
// ---------------------------------------------------------------------------
// bresp_route_ctrl_sel_fifo
// In-order FIFO of 1-bit owner IDs, Depth entries deep (power of two).
// Pushes while full and pops while empty are ignored.
// Ports:
//   i_clk, i_rst       clock, asynchronous active-high reset
//   i_push, i_din      push request and owner bit
//   i_pop              pop request
//   o_head             owner at the read pointer (only meaningful when !o_empty)
//   o_full, o_empty    occupancy flags, decoded from the registered count
//   o_count            number of stored entries
// ---------------------------------------------------------------------------
module bresp_route_ctrl_sel_fifo
   import bresp_route_ctrl_pkg::*;
#(
   parameter int Depth = DEFAULT_DEPTH,
   localparam int PTR_W = $clog2(Depth),
   localparam int CNT_W = $clog2(Depth + 1)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_push,
   input  logic             i_din,
   input  logic             i_pop,
   output logic             o_head,
   output logic             o_full,
   output logic             o_empty,
   output logic [CNT_W-1:0] o_count
);

   logic [PTR_W-1:0] r_wptr;
   logic [PTR_W-1:0] r_rptr;
   logic [CNT_W-1:0] r_count;
   logic             r_mem [Depth];

   logic w_push;
   logic w_pop;

   assign o_full  = (r_count == CNT_W'(Depth));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_head  = r_mem[r_rptr];

   // Full has no pop bypass: a push while full is dropped even if a pop
   // happens in the same cycle.
   assign w_push = i_push & ~o_full;
   assign w_pop  = i_pop & ~o_empty;

   // Pointers are exactly log2(Depth) bits wide, so they wrap on overflow.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage needs no reset; an entry is only read after it has been written.
   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wptr] <= i_din;
   end

endmodule : bresp_route_ctrl_sel_fifo

// File: rtl/bresp_route_ctrl.sv
// ---------------------------------------------------------------------------
// bresp_route_ctrl
// Write-response router for a two-master AXI interconnect. Records the owner
// of each accepted AW in order and steers the slave B channel to that owner.
// Ports:
//   ACLK, ARESET                 clock, asynchronous active-high reset
//   AW_Accept, AW_Master_Sel     AW handshake done this cycle, and its owner
//   AW_Stall                     tracking full; arbiter must hold AWREADY low
//   S_BVALID, S_BRESP, S_BREADY  slave-side B channel
//   Sel                          head owner, drives the B demux select line
//   Mx_BVALID, Mx_BRESP          per-master B channel outputs
//   Mx_BREADY                    per-master B ready inputs
//   Outstanding                  writes awaiting a response
//   Orphan_Resp                  sticky: S_BVALID seen with nothing outstanding
// ---------------------------------------------------------------------------
module bresp_route_ctrl
   import bresp_route_ctrl_pkg::*;
#(
   parameter int Depth      = DEFAULT_DEPTH,
   parameter int Resp_Width = BRESP_W
) (
   input  logic                           ACLK,
   input  logic                           ARESET,
   input  logic                           AW_Accept,
   input  logic                           AW_Master_Sel,
   output logic                           AW_Stall,
   input  logic                           S_BVALID,
   input  logic [Resp_Width-1:0]          S_BRESP,
   output logic                           S_BREADY,
   output logic                           Sel,
   output logic                           M0_BVALID,
   output logic                           M1_BVALID,
   output logic [Resp_Width-1:0]          M0_BRESP,
   output logic [Resp_Width-1:0]          M1_BRESP,
   input  logic                           M0_BREADY,
   input  logic                           M1_BREADY,
   output logic [$clog2(Depth+1)-1:0]     Outstanding,
   output logic                           Orphan_Resp
);

   logic w_head;
   logic w_full;
   logic w_empty;
   logic w_pop;
   logic r_orphan;

   // S_BREADY is already forced low when empty, so this is the full pop term.
   assign w_pop = S_BVALID & S_BREADY;

   bresp_route_ctrl_sel_fifo #(
      .Depth (Depth)
   ) u_sel_fifo (
      .i_clk   (ACLK),
      .i_rst   (ARESET),
      .i_push  (AW_Accept),
      .i_din   (AW_Master_Sel),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (Outstanding)
   );

   assign AW_Stall    = w_full;
   assign Orphan_Resp = r_orphan;

   // Zero-latency B path: routing depends only on registered FIFO state and
   // the live B-channel inputs, so Sel cannot move while a beat is stalled.
   always_comb begin
      Sel       = MASTER_0;
      M0_BVALID = 1'b0;
      M1_BVALID = 1'b0;
      M0_BRESP  = '0;
      M1_BRESP  = '0;
      S_BREADY  = 1'b0;
      if (!w_empty) begin
         Sel = w_head;
         if (w_head == MASTER_1) begin
            M1_BVALID = S_BVALID;
            M1_BRESP  = S_BRESP;
            S_BREADY  = M1_BREADY;
         end else begin
            M0_BVALID = S_BVALID;
            M0_BRESP  = S_BRESP;
            S_BREADY  = M0_BREADY;
         end
      end
   end

   // A response with nothing outstanding has no owner; flag it until reset.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) r_orphan <= 1'b0;
      else        r_orphan <= r_orphan | (w_empty & S_BVALID);
   end

endmodule : bresp_route_ctrl

// File: doc/bresp_route_ctrl.md
# bresp_route_ctrl

Write-response routing controller for the two-master AXI interconnect. It records the owning master of every accepted write address in order, then steers the slave's B channel (BVALID/BRESP out, BREADY back) to that master. It drives the select line of the B-channel 1:2 demux, so it sits directly upstream of that demux. It also throttles AW acceptance when its outstanding-write tracking is full.

## Interface
Parameters:
- Depth, 4: maximum outstanding writes tracked; power of two, ≥2.
- Resp_Width, 2: BRESP width.

Ports:
- ACLK  in  1  clock; all state updates on rising edge.
- ARESET  in  1  asynchronous, active-high reset.
- AW_Accept  in  1  slave-side AW handshake completed this cycle (AWVALID & AWREADY).
- AW_Master_Sel  in  1  owner of the accepted AW: 0 = M0, 1 = M1. Sampled only when AW_Accept is high.
- AW_Stall  out  1  tracking full; the AW arbiter must hold AWREADY low.
- S_BVALID  in  1  slave write-response valid.
- S_BRESP  in  Resp_Width  slave write response.
- S_BREADY  out  1  ready returned to the slave.
- Sel  out  1  head-entry owner; drives the B-channel demux Selection_Line.
- M0_BVALID / M1_BVALID  out  1  per-master response valid.
- M0_BRESP / M1_BRESP  out  Resp_Width  per-master response.
- M0_BREADY / M1_BREADY  in  1  per-master ready.
- Outstanding  out  $clog2(Depth+1)  count of writes awaiting B.
- Orphan_Resp  out  1  sticky flag: S_BVALID was seen while nothing was outstanding.

## Operation
- The block holds an in-order FIFO of 1-bit owner IDs, Depth entries deep.
  - Write pointer, read pointer and count are all registered.
  - Pointers wrap modulo Depth.
- Push: AW_Accept & !full writes AW_Master_Sel at the write pointer, increments the write pointer and increments the count.
- AW_Accept while full is a protocol violation by the arbiter. The block ignores it; no state changes.
- AW_Stall = full (count == Depth). There is no bypass: a pop in the same cycle does not release the stall.
- Sel = FIFO head when non-empty; 0 when empty.
- Routing when non-empty:
  - Mx_BVALID = S_BVALID for the selected master only; the other master's BVALID is 0.
  - Both Mx_BRESP ports carry S_BRESP when selected and 0 otherwise.
  - S_BREADY = the selected master's BREADY.
- When empty:
  - Both Mx_BVALID are 0 and S_BREADY is 0, so the slave stalls.
  - If S_BVALID is high, Orphan_Resp sets and stays set until reset.
- Pop: non-empty & S_BVALID & S_BREADY. The read pointer increments and the count decrements.
- Simultaneous push and pop: both pointers advance and the count is unchanged.
- Outstanding equals the count.

## Timing
- Reset values: pointers 0, count 0, Sel 0, AW_Stall 0, Outstanding 0, Orphan_Resp 0, all BVALID/BRESP 0, S_BREADY 0.
- A pushed entry becomes visible at the head on the cycle after the push edge. A B response cannot be routed in the same cycle as its own AW.
- Sel, Mx_BVALID, Mx_BRESP and S_BREADY are combinational from registered state plus the current S_BVALID/S_BRESP/Mx_BREADY. This path is zero-latency; there is no register stage in the B path.
- Sel changes only on a pop edge or on the empty→non-empty edge. It is stable while a response is stalled (S_BVALID high, BREADY low).
- AW_Stall asserts on the edge where the count reaches Depth. It deasserts on the edge after the first pop from full.
- ARESET asserted mid-transaction clears all tracking immediately (asynchronously). Any in-flight responses become orphans.

## Structure
- The shared interconnect package holds:
  - the master index constants (MASTER_0 = 1'b0, MASTER_1 = 1'b1);
  - the default Depth;
  - the BRESP width constant.
- One sub-module is natural: sel_fifo. It is a synchronous 1-bit-wide FIFO with push, pop, full, empty and count outputs, and uses the same asynchronous active-high reset.
- The top level adds only the routing muxes and the orphan flag.

## Test plan
- AW_Accept with Sel 0, then Sel 1, then Sel 0. Then three S_BVALID beats with S_BRESP 2'b00, 2'b10, 2'b00, both BREADY high. Required: M0, M1, M0 each receive exactly one BVALID, with the matching BRESP; Outstanding goes 3→0.
- Push four entries with Depth=4. Required: AW_Stall=1 after the fourth push; a fifth AW_Accept changes nothing. One pop, then AW_Stall=0 on the next cycle.
- Head owner M1; S_BVALID held, M1_BREADY low for 3 cycles, then high. Required: Sel stays 1, S_BREADY low for 3 cycles, a single pop, M0_BVALID never asserts.
- Count=2 with a push and a pop in the same cycle. Required: Outstanding stays 2. Pointers wrap correctly across more than Depth total transactions, with owner order preserved.
- S_BVALID with FIFO empty. Required: S_BREADY=0, both Mx_BVALID=0, Orphan_Resp=1 and sticky until ARESET.
- ARESET pulsed with 3 writes outstanding. Required: all outputs return to their reset values immediately, and Outstanding=0.
